// File: rtl/mips_harvard_memory.sv
// Harvard-style instruction/data memory for a MIPS core.
// It has a LOAD phase, in which an external loader fills both arrays, and a
// RUN phase, in which the core fetches instructions and does data accesses.
// Accesses outside either window raise a sticky fault and record the first
// faulting address.

module mips_harvard_memory #(
    parameter logic [31:0] IMEM_BASE  = 32'hBFC00000,
    parameter int          IMEM_WORDS = 1024,
    parameter logic [31:0] DMEM_BASE  = 32'h00000000,
    parameter int          DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic        load_sel,
    input  logic [15:0] load_index,
    input  logic [31:0] load_data,
    input  logic        load_done,
    output logic        fault,
    output logic [31:0] fault_address,
    output logic [15:0] write_count
);

    localparam int IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam int DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) << 2;
    localparam logic [32:0] DMEM_BYTES = 33'(DMEM_WORDS) << 2;

    typedef enum logic {
        LOAD,
        RUN
    } state_t;

    state_t state;
    state_t next_state;

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];

    logic [31:0]    i_off;
    logic [31:0]    d_off;
    logic           i_in_win;
    logic           d_in_win;
    logic [IAW-1:0] i_idx;
    logic [DAW-1:0] d_idx;
    logic [IAW-1:0] load_iidx;
    logic [DAW-1:0] load_didx;
    logic           data_fault;
    logic           instr_fault;
    logic           commit_write;

    // Window decode: the offset from the base selects the word, and the low
    // two address bits are simply dropped.
    always_comb begin
        i_off     = instr_address - IMEM_BASE;
        d_off     = data_address - DMEM_BASE;
        i_in_win  = (instr_address >= IMEM_BASE) && ({1'b0, i_off} < IMEM_BYTES);
        d_in_win  = (data_address >= DMEM_BASE) && ({1'b0, d_off} < DMEM_BYTES);
        i_idx     = i_off[IAW+1:2];
        d_idx     = d_off[DAW+1:2];
        load_iidx = IAW'(load_index);
        load_didx = DAW'(load_index);
    end

    // Zero-latency read ports; an out-of-window or idle access returns zero.
    always_comb begin
        instr_readdata = i_in_win ? imem[i_idx] : 32'h0;
        data_readdata  = (data_read && d_in_win) ? dmem[d_idx] : 32'h0;
    end

    // Fault and commit conditions, all qualified by RUN and blocked by reset.
    always_comb begin
        data_fault   = (state == RUN) && (data_read || data_write) && !d_in_win;
        instr_fault  = (state == RUN) && !i_in_win && (instr_address != 32'h0);
        commit_write = !reset && (state == RUN) && data_write && d_in_win;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= next_state;
    end

    // Next-state logic: one-way transition from LOAD to RUN.
    always_comb begin
        next_state = state;
        if (state == LOAD && load_done) next_state = RUN;
    end

    // FSM outputs.
    always_comb begin
        load_ready = (state == LOAD);
    end

    // Instruction array: written only by the loader; not cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && state == LOAD && load_valid && !load_sel)
            imem[load_iidx] <= load_data;
    end

    // Data array: loader writes in LOAD, core writes in RUN; not cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && state == LOAD && load_valid && load_sel)
            dmem[load_didx] <= load_data;
        else if (commit_write)
            dmem[d_idx] <= data_writedata;
    end

    // Sticky fault; the first faulting address is kept and the data port wins ties.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault         <= 1'b0;
            fault_address <= 32'h0;
        end else if (!fault && (data_fault || instr_fault)) begin
            fault         <= 1'b1;
            fault_address <= data_fault ? data_address : instr_address;
        end
    end

    // Saturating count of committed core writes.
    always_ff @(posedge clk) begin
        if (reset)
            write_count <= 16'h0;
        else if (commit_write && write_count != 16'hFFFF)
            write_count <= write_count + 16'h1;
    end

endmodule

// File: tb/tb_mips_harvard_memory.sv
// Scoreboard bench for mips_harvard_memory. The stimulus pushes the expected
// output values for each cycle into a queue, and a monitor pops them and
// compares them on the falling edge.

module tb_mips_harvard_memory;

    localparam int K_INSTR  = 0;
    localparam int K_DATA   = 1;
    localparam int K_FAULT  = 2;
    localparam int K_FADDR  = 3;
    localparam int K_WCOUNT = 4;
    localparam int K_READY  = 5;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        load_valid;
    logic        load_ready;
    logic        load_sel;
    logic [15:0] load_index;
    logic [31:0] load_data;
    logic        load_done;
    logic        fault;
    logic [31:0] fault_address;
    logic [15:0] write_count;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    mips_harvard_memory dut (
        .clk            (clk),
        .reset          (reset),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_sel       (load_sel),
        .load_index     (load_index),
        .load_data      (load_data),
        .load_done      (load_done),
        .fault          (fault),
        .fault_address  (fault_address),
        .write_count    (write_count)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter so that expectations can be tagged with their cycle.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sampleOutput(input int kind);
        case (kind)
            K_INSTR:  return instr_readdata;
            K_DATA:   return data_readdata;
            K_FAULT:  return {31'h0, fault};
            K_FADDR:  return fault_address;
            K_WCOUNT: return {16'h0, write_count};
            default:  return {31'h0, load_ready};
        endcase
    endfunction

    // Monitor: pops every expectation that is due this cycle and compares it.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e   = sb.pop_front();
            act = sampleOutput(e.kind);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("[TB] FAIL %s: got %08h, expected %08h (cycle %0d)", e.name, act, e.exp, cyc);
            end
        end
    end

    // Queues an expected output value for the current cycle.
    task automatic checkOutput(input int kind, input logic [31:0] exp, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    // Moves to the next cycle and returns all single-cycle strobes to idle.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        reset      = 1'b0;
        load_valid = 1'b0;
        load_done  = 1'b0;
        data_read  = 1'b0;
        data_write = 1'b0;
    endtask

    task automatic loadBeat(input logic sel, input logic [15:0] idx, input logic [31:0] dat);
        load_valid = 1'b1;
        load_sel   = sel;
        load_index = idx;
        load_data  = dat;
    endtask

    initial begin
        reset          = 1'b1;
        instr_address  = 32'h0;
        data_address   = 32'h0;
        data_read      = 1'b0;
        data_write     = 1'b0;
        data_writedata = 32'h0;
        load_valid     = 1'b0;
        load_sel       = 1'b0;
        load_index     = 16'h0;
        load_data      = 32'h0;
        load_done      = 1'b0;

        @(posedge clk);
        #1;
        reset = 1'b1;

        // Post-reset state, then the first loader beat into data word 8.
        applyStimulus();
        checkOutput(K_READY,  32'h1, "reset_load_ready");
        checkOutput(K_FAULT,  32'h0, "reset_fault");
        checkOutput(K_FADDR,  32'h0, "reset_fault_address");
        checkOutput(K_WCOUNT, 32'h0, "reset_write_count");
        loadBeat(1'b1, 16'd8, 32'h00000055);

        // A core write during LOAD must be ignored.
        applyStimulus();
        loadBeat(1'b0, 16'd0, 32'h24020005);
        data_write     = 1'b1;
        data_address   = 32'h00000020;
        data_writedata = 32'h00000BAD;

        applyStimulus();
        checkOutput(K_WCOUNT, 32'h0, "load_write_not_counted");
        loadBeat(1'b1, 16'd2, 32'h00000011);

        // Index 1025 wraps to instruction word 1.
        applyStimulus();
        loadBeat(1'b0, 16'd1025, 32'h3C08ABCD);

        applyStimulus();
        load_done     = 1'b1;
        instr_address = 32'hBFC00000;
        checkOutput(K_READY, 32'h1, "ready_during_done");
        checkOutput(K_INSTR, 32'h24020005, "fetch_word0");

        // RUN: fetch the wrapped word, write, and try an ignored loader beat.
        applyStimulus();
        checkOutput(K_READY, 32'h0, "run_not_ready");
        instr_address = 32'hBFC00004;
        checkOutput(K_INSTR, 32'h3C08ABCD, "fetch_word1_modulo");
        data_write     = 1'b1;
        data_address   = 32'h00000010;
        data_writedata = 32'hDEADBEEF;
        loadBeat(1'b1, 16'd8, 32'h00000099);
        load_done = 1'b1;

        applyStimulus();
        data_read    = 1'b1;
        data_address = 32'h00000013;
        checkOutput(K_DATA,   32'hDEADBEEF, "read_after_write");
        checkOutput(K_WCOUNT, 32'h1, "write_count_1");

        // Same-cycle read and write of one word returns the old contents.
        applyStimulus();
        data_read      = 1'b1;
        data_write     = 1'b1;
        data_address   = 32'h00000008;
        data_writedata = 32'h00000022;
        checkOutput(K_DATA, 32'h00000011, "raw_old_value");

        applyStimulus();
        data_read    = 1'b1;
        data_address = 32'h00000008;
        checkOutput(K_DATA,   32'h00000022, "raw_new_value");
        checkOutput(K_WCOUNT, 32'h2, "write_count_2");

        applyStimulus();
        data_read    = 1'b1;
        data_address = 32'h00000020;
        checkOutput(K_DATA,  32'h00000055, "gated_writes_ignored");
        checkOutput(K_FAULT, 32'h0, "no_fault_yet");

        // The first out-of-window data read.
        applyStimulus();
        data_read    = 1'b1;
        data_address = 32'h00001000;
        checkOutput(K_DATA,  32'h0, "oow_read_zero");
        checkOutput(K_FAULT, 32'h0, "fault_not_before_edge");

        applyStimulus();
        checkOutput(K_FAULT, 32'h1, "fault_set");
        checkOutput(K_FADDR, 32'h00001000, "fault_address_first");
        data_write     = 1'b1;
        data_address   = 32'h00002000;
        data_writedata = 32'h00000077;

        applyStimulus();
        checkOutput(K_FADDR,  32'h00001000, "fault_address_sticky");
        checkOutput(K_WCOUNT, 32'h2, "oow_write_not_counted");

        // Reset dominates a simultaneous write and loader beat.
        applyStimulus();
        reset          = 1'b1;
        data_write     = 1'b1;
        data_address   = 32'h00000008;
        data_writedata = 32'h00000033;
        loadBeat(1'b1, 16'd2, 32'h00000044);

        applyStimulus();
        checkOutput(K_WCOUNT, 32'h0, "reset2_write_count");
        checkOutput(K_FAULT,  32'h0, "reset2_fault");
        checkOutput(K_FADDR,  32'h0, "reset2_fault_address");
        checkOutput(K_READY,  32'h1, "reset2_ready");
        instr_address = 32'h0;
        load_done     = 1'b1;

        applyStimulus();
        checkOutput(K_READY, 32'h0, "run2_not_ready");
        checkOutput(K_INSTR, 32'h0, "fetch_addr0_zero");
        data_read    = 1'b1;
        data_address = 32'h00000008;
        checkOutput(K_DATA, 32'h00000022, "data_retained_over_reset");

        // A zero fetch address never faults; then data and fetch fault together.
        applyStimulus();
        checkOutput(K_FAULT, 32'h0, "addr0_no_fault");
        data_read     = 1'b1;
        data_address  = 32'h00003000;
        instr_address = 32'h00400000;
        checkOutput(K_INSTR, 32'h0, "fetch_oow_zero");

        applyStimulus();
        instr_address = 32'hBFC00000;
        checkOutput(K_FAULT, 32'h1, "fault2_set");
        checkOutput(K_FADDR, 32'h00003000, "fault_data_priority");

        applyStimulus();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
